// File: rtl/ssd1306_pkg.sv
// Shared opcodes, decoder state and addressing-mode types for the SSD1306 SPI receiver.
package ssd1306_pkg;

    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
    localparam logic [7:0] CMD_VCOMH       = 8'hDB;
    localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;

    typedef enum logic [1:0] {
        S_CMD    = 2'd0,
        S_PARAM1 = 2'd1,
        S_PARAM2 = 2'd2
    } dec_state_t;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addr_mode_t;

    // Number of parameter bytes that follow a command opcode.
    function automatic logic [1:0] param_count(input logic [7:0] op);
        case (op)
            CMD_CONTRAST, CMD_ADDR_MODE, CMD_CHARGE_PUMP, CMD_MUX_RATIO,
            CMD_DISP_OFFSET, CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS,
            CMD_VCOMH:                   param_count = 2'd1;
            CMD_COL_ADDR, CMD_PAGE_ADDR: param_count = 2'd2;
            default:                     param_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_if.sv
// OLED pin bundle plus framebuffer-write and status outputs of the SSD1306 receiver.
interface ssd1306_spi_receiver_if #(
    parameter int COLS  = 128,
    parameter int PAGES = 4
);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    logic              oled_csn_in;
    logic              oled_dc_in;
    logic              oled_clk_in;
    logic              oled_mosi_in;
    logic [PW+CW-1:0]  fb_addr_out;
    logic [7:0]        fb_data_out;
    logic              fb_write_stb_out;
    logic              display_on_out;
    logic [7:0]        contrast_out;
    logic              frame_err_stb_out;

    modport master (
        output oled_csn_in, oled_dc_in, oled_clk_in, oled_mosi_in,
        input  fb_addr_out, fb_data_out, fb_write_stb_out,
        input  display_on_out, contrast_out, frame_err_stb_out
    );

    modport slave (
        input  oled_csn_in, oled_dc_in, oled_clk_in, oled_mosi_in,
        output fb_addr_out, fb_data_out, fb_write_stb_out,
        output display_on_out, contrast_out, frame_err_stb_out
    );
endinterface

// File: rtl/ssd1306_spi_byte_rx.sv
// Pin synchronizers, SCK edge detect and byte assembly for the SSD1306 SPI link.
module ssd1306_spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       csn_pin,
    input  logic       dc_pin,
    input  logic       sck_pin,
    input  logic       mosi_pin,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       frame_err
);
    logic [SYNC_STAGES-1:0] csn_sync, dc_sync, sck_sync, mosi_sync;
    logic       csn_s, dc_s, sck_s, mosi_s;
    logic       sck_prev, csn_prev, sck_rise;
    logic [6:0] shift;
    logic [2:0] bit_cnt;

    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            csn_sync  <= '1;
            dc_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn_pin};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc_pin};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
        end
    end

    // The frame-error test sees the bit count from before the deselect clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sck_prev   <= 1'b0;
            csn_prev   <= 1'b1;
            shift      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sck_prev   <= sck_s;
            csn_prev   <= csn_s;
            byte_valid <= 1'b0;
            frame_err  <= csn_s & ~csn_prev & (bit_cnt != 3'd0);
            if (csn_s) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shift   <= {shift[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_s};
                    byte_dc    <= dc_s;
                end
            end
        end
    end
endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 command decoder and framebuffer write-address generator.
// Optional page addressing mode is enabled by defining SSD1306_RX_PAGE_MODE_EN.
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int COLS        = 128,
    parameter int PAGES       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_in,
    input  logic                   resetn_in,
    ssd1306_spi_receiver_if.slave  oled
);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);
`ifdef SSD1306_RX_PAGE_MODE_EN
    localparam addr_mode_t RESET_MODE = MODE_PAGE;
`else
    localparam addr_mode_t RESET_MODE = MODE_HORIZ;
`endif

    logic       byte_valid, byte_dc, frame_err;
    logic [7:0] byte_data;

    dec_state_t state, next_state;
    addr_mode_t mode_q, mode_d;
    logic [7:0] cmd_q, cmd_d, param_q, param_d, contrast_q, contrast_d, data_q, data_d;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic [PW+CW-1:0] addr_q, addr_d;
    logic disp_q, disp_d, stb_q, stb_d;

    ssd1306_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk        (clk_in),
        .resetn     (resetn_in),
        .csn_pin    (oled.oled_csn_in),
        .dc_pin     (oled.oled_dc_in),
        .sck_pin    (oled.oled_clk_in),
        .mosi_pin   (oled.oled_mosi_in),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk_in) begin
        if (!resetn_in) state <= S_CMD;
        else            state <= next_state;
    end

    // A data byte always returns the decoder to command state.
    always_comb begin
        next_state = state;
        if (byte_valid) begin
            if (byte_dc) begin
                next_state = S_CMD;
            end else begin
                case (state)
                    S_CMD:    next_state = (param_count(byte_data) != 2'd0) ? S_PARAM1 : S_CMD;
                    S_PARAM1: next_state = (param_count(cmd_q) == 2'd2) ? S_PARAM2 : S_CMD;
                    default:  next_state = S_CMD;
                endcase
            end
        end
    end

    // Address windows are committed only once both parameters have arrived.
    always_comb begin
`ifdef SSD1306_RX_PAGE_MODE_EN
        logic [7:0] col8;
        col8 = 8'(col_q);
`endif
        cmd_d = cmd_q;  param_d = param_q;  mode_d = mode_q;
        col_d = col_q;  col_start_d = col_start_q;  col_end_d = col_end_q;
        page_d = page_q;  page_start_d = page_start_q;  page_end_d = page_end_q;
        disp_d = disp_q;  contrast_d = contrast_q;
        addr_d = addr_q;  data_d = data_q;  stb_d = 1'b0;
        if (byte_valid && byte_dc) begin
            addr_d = {page_q, col_q};
            data_d = byte_data;
            stb_d  = 1'b1;
            if (mode_q == MODE_VERT) begin
                if (page_q == page_end_q) begin
                    page_d = page_start_q;
                    col_d  = (col_q == col_end_q) ? col_start_q : col_q + CW'(1);
                end else begin
                    page_d = page_q + PW'(1);
                end
`ifdef SSD1306_RX_PAGE_MODE_EN
            end else if (mode_q == MODE_PAGE) begin
                col_d = (col_q == CW'(COLS-1)) ? '0 : col_q + CW'(1);
`endif
            end else begin
                if (col_q == col_end_q) begin
                    col_d  = col_start_q;
                    page_d = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end else if (byte_valid) begin
            case (state)
                S_CMD: begin
                    cmd_d = byte_data;
                    case (byte_data)
                        CMD_DISPLAY_OFF: disp_d = 1'b0;
                        CMD_DISPLAY_ON:  disp_d = 1'b1;
                        default: ;
                    endcase
`ifdef SSD1306_RX_PAGE_MODE_EN
                    if (byte_data[7:4] == 4'h0)     col_d  = CW'({col8[7:4], byte_data[3:0]});
                    if (byte_data[7:4] == 4'h1)     col_d  = CW'({byte_data[3:0], col8[3:0]});
                    if (byte_data[7:3] == 5'b10110) page_d = PW'(byte_data[2:0]);
`endif
                end
                S_PARAM1: begin
                    param_d = byte_data;
                    case (cmd_q)
                        CMD_CONTRAST: contrast_d = byte_data;
                        CMD_ADDR_MODE: begin
                            case (byte_data[1:0])
                                2'd0: mode_d = MODE_HORIZ;
                                2'd1: mode_d = MODE_VERT;
`ifdef SSD1306_RX_PAGE_MODE_EN
                                2'd2: mode_d = MODE_PAGE;
`endif
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                S_PARAM2: begin
                    case (cmd_q)
                        CMD_COL_ADDR: begin
                            col_start_d = CW'(param_q);
                            col_end_d   = CW'(byte_data);
                            col_d       = CW'(param_q);
                        end
                        CMD_PAGE_ADDR: begin
                            page_start_d = PW'(param_q);
                            page_end_d   = PW'(byte_data);
                            page_d       = PW'(param_q);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            cmd_q <= '0;  param_q <= '0;  mode_q <= RESET_MODE;
            col_q <= '0;  col_start_q <= '0;  col_end_q <= CW'(COLS-1);
            page_q <= '0;  page_start_q <= '0;  page_end_q <= PW'(PAGES-1);
            disp_q <= 1'b0;  contrast_q <= 8'h7F;
            addr_q <= '0;  data_q <= '0;  stb_q <= 1'b0;
        end else begin
            cmd_q <= cmd_d;  param_q <= param_d;  mode_q <= mode_d;
            col_q <= col_d;  col_start_q <= col_start_d;  col_end_q <= col_end_d;
            page_q <= page_d;  page_start_q <= page_start_d;  page_end_q <= page_end_d;
            disp_q <= disp_d;  contrast_q <= contrast_d;
            addr_q <= addr_d;  data_q <= data_d;  stb_q <= stb_d;
        end
    end

    assign oled.fb_addr_out       = addr_q;
    assign oled.fb_data_out       = data_q;
    assign oled.fb_write_stb_out  = stb_q;
    assign oled.display_on_out    = disp_q;
    assign oled.contrast_out      = contrast_q;
    assign oled.frame_err_stb_out = frame_err;
endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Directed self-checking bench for ssd1306_spi_receiver; honours SSD1306_RX_PAGE_MODE_EN.
module tb_ssd1306_spi_receiver;
    localparam int HALF = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ssd1306_spi_receiver_if #(.COLS(128), .PAGES(4)) oled ();

    ssd1306_spi_receiver #(.COLS(128), .PAGES(4), .SYNC_STAGES(2)) dut (
        .clk_in    (clk),
        .resetn_in (resetn),
        .oled      (oled)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_cnt = 0;
    int last_rise_cyc = 0;
    int stb_cyc = 0;
    int disp_rise_cyc = 0;
    int ferr_cnt = 0;
    logic disp_prev = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr[7];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Capture every write strobe and status edge half a cycle after the clock.
    always @(negedge clk) begin
        if (oled.fb_write_stb_out === 1'b1) begin
            wr_addr_q.push_back(32'(oled.fb_addr_out));
            wr_data_q.push_back(32'(oled.fb_data_out));
            stb_cyc = cyc_cnt;
        end
        if (oled.frame_err_stb_out === 1'b1) ferr_cnt++;
        if (oled.display_on_out === 1'b1 && disp_prev === 1'b0) disp_rise_cyc = cyc_cnt;
        disp_prev = oled.display_on_out;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_write(input string tag, input logic [31:0] ea, input logic [31:0] ed);
        logic [31:0] ga;
        logic [31:0] gd;
        ga = 'x;
        gd = 'x;
        if (wr_addr_q.size() > 0) begin
            ga = wr_addr_q.pop_front();
            gd = wr_data_q.pop_front();
        end
        check_output({tag, "_addr"}, ga, ea);
        check_output({tag, "_data"}, gd, ed);
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic dc, input int n);
        oled.oled_dc_in = dc;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            oled.oled_mosi_in = b[i];
            repeat (HALF) @(negedge clk);
            oled.oled_clk_in = 1'b1;
            last_rise_cyc = cyc_cnt;
            repeat (HALF) @(negedge clk);
            oled.oled_clk_in = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        apply_stimulus(b, dc, 8);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        oled.oled_csn_in = 1'b1;
        oled.oled_clk_in = 1'b0;
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        oled.oled_csn_in  = 1'b1;
        oled.oled_dc_in   = 1'b0;
        oled.oled_clk_in  = 1'b0;
        oled.oled_mosi_in = 1'b0;

        // Reset values
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        check_output("rst_addr",     32'(oled.fb_addr_out), 32'h0);
        check_output("rst_data",     32'(oled.fb_data_out), 32'h0);
        check_output("rst_stb",      32'(oled.fb_write_stb_out), 32'h0);
        check_output("rst_disp",     32'(oled.display_on_out), 32'h0);
        check_output("rst_contrast", 32'(oled.contrast_out), 32'h7F);
        check_output("rst_ferr",     32'(oled.frame_err_stb_out), 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Display on, latency, contrast
        oled.oled_csn_in = 1'b0;
        send_byte(8'hAF, 1'b0);
        check_output("disp_on", 32'(oled.display_on_out), 32'h1);
        check_output("disp_latency", 32'(disp_rise_cyc - last_rise_cyc), 32'd4);
        send_byte(8'h81, 1'b0);
        send_byte(8'h3C, 1'b0);
        check_output("contrast", 32'(oled.contrast_out), 32'h3C);

        // Horizontal mode over the full panel, then wrap to address 0
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 513; i++) send_byte(8'(i), 1'b1);
        check_output("hz_count", 32'(wr_addr_q.size()), 32'd513);
        check_output("wr_latency", 32'(stb_cyc - last_rise_cyc), 32'd4);
        for (int i = 0; i < 512; i++) check_write($sformatf("hz_%0d", i), 32'(i), 32'(i % 256));
        check_write("hz_wrap", 32'h0, 32'h0);

        // Windowed horizontal addressing
        send_byte(8'h21, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h12, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        exp_addr = '{32'h090, 32'h091, 32'h092, 32'h110, 32'h111, 32'h112, 32'h090};
        for (int k = 0; k < 7; k++) send_byte(8'hC0 + 8'(k), 1'b1);
        for (int k = 0; k < 7; k++) check_write($sformatf("win_%0d", k), exp_addr[k], 32'hC0 + 32'(k));

        // Deselect mid-byte, then a clean data byte at the next pointer {1,0x11}
        ferr_cnt = 0;
        apply_stimulus(8'hFF, 1'b1, 5);
        repeat (2) @(negedge clk);
        oled.oled_csn_in = 1'b1;
        repeat (10) @(negedge clk);
        check_output("ferr_pulses", 32'(ferr_cnt), 32'd1);
        check_output("ferr_no_write", 32'(wr_addr_q.size()), 32'd0);
        oled.oled_csn_in = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        check_write("after_ferr", 32'h091, 32'hA5);
        check_output("ferr_once", 32'(ferr_cnt), 32'd1);

        // Abandoned 0x21 parameter list: data goes to current pointer, window unchanged
        send_byte(8'h21, 1'b0); send_byte(8'h05, 1'b0);
        send_byte(8'h55, 1'b1);
        check_write("abandon", 32'h092, 32'h55);
        send_byte(8'hAE, 1'b0);
        check_output("disp_off", 32'(oled.display_on_out), 32'h0);
        send_byte(8'h66, 1'b1);
        check_write("abandon_wrap", 32'h110, 32'h66);

        // Page-mode commands from reset
        do_reset();
        check_output("rst2_contrast", 32'(oled.contrast_out), 32'h7F);
        check_output("rst2_addr", 32'(oled.fb_addr_out), 32'h0);
        oled.oled_csn_in = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hB2, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h17, 1'b0);
        send_byte(8'h3C, 1'b1);
`ifdef SSD1306_RX_PAGE_MODE_EN
        check_write("page_cmd", 32'h173, 32'h3C);
`else
        check_write("page_cmd", 32'h000, 32'h3C);
`endif
        check_output("page_cmd_extra", 32'(wr_addr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
